// File: rtl/expye_pipe_cpu.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) executing ALU operations only.
// All operand hazards are resolved by forwarding into ID, so the pipeline never stalls or flushes.
module expye_pipe_cpu #(
    parameter int                      ROM_DEPTH = 128,
    parameter logic [ROM_DEPTH*32-1:0] ROM_INIT  = '0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] dbg_pc,
    output logic        dbg_wb_we,
    output logic [4:0]  dbg_wb_addr,
    output logic [31:0] dbg_wb_data
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    typedef enum logic [3:0] {
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_PASSB
    } aluOp_e;

    logic [31:0]       pcQ, pcD;
    logic [ROM_AW+1:0] pcLowNext;
    logic [ROM_AW-1:0] romAddr;
    logic [31:0]       fetchInst;

    logic [31:0]       ifIdInstQ;

    logic              idExWeQ, idExWeD;
    logic [4:0]        idExDestQ, idExDestD;
    aluOp_e            idExOpQ, idExOpD;
    logic [31:0]       idExAQ, idExAD;
    logic [31:0]       idExBQ, idExBD;
    logic [4:0]        idExShQ, idExShD;

    logic [31:0]       exResult;

    logic              exMemWeQ;
    logic [4:0]        exMemDestQ;
    logic [31:0]       exMemDataQ;

    logic              memWbWeQ;
    logic [4:0]        memWbDestQ;
    logic [31:0]       memWbDataQ;

    logic [31:0]       gprQ [32];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, sa;
    logic [15:0]       imm;
    logic [31:0]       rsVal, rtVal;

    // The PC only ever walks the ROM window, so the upper bits stay zero.
    assign pcLowNext = pcQ[ROM_AW+1:0] + (ROM_AW+2)'(4);
    assign pcD       = 32'(pcLowNext);
    assign romAddr   = pcQ[ROM_AW+1:2];
    assign fetchInst = ROM_INIT[{romAddr, 5'd0} +: 32];

    assign opcode = ifIdInstQ[31:26];
    assign rs     = ifIdInstQ[25:21];
    assign rt     = ifIdInstQ[20:16];
    assign rd     = ifIdInstQ[15:11];
    assign sa     = ifIdInstQ[10:6];
    assign funct  = ifIdInstQ[5:0];
    assign imm    = ifIdInstQ[15:0];

    function automatic logic [31:0] forwardOperand(
        input logic [4:0]  addr,
        input logic        exWe,
        input logic [4:0]  exDest,
        input logic [31:0] exData,
        input logic        memWe,
        input logic [4:0]  memDest,
        input logic [31:0] memData,
        input logic        wbWe,
        input logic [4:0]  wbDest,
        input logic [31:0] wbData,
        input logic [31:0] regData
    );
        if (addr == 5'd0) return '0;
        if (exWe && exDest == addr) return exData;
        if (memWe && memDest == addr) return memData;
        if (wbWe && wbDest == addr) return wbData;
        return regData;
    endfunction

    assign rsVal = forwardOperand(rs, idExWeQ, idExDestQ, exResult, exMemWeQ, exMemDestQ,
                                  exMemDataQ, memWbWeQ, memWbDestQ, memWbDataQ, gprQ[rs]);
    assign rtVal = forwardOperand(rt, idExWeQ, idExDestQ, exResult, exMemWeQ, exMemDestQ,
                                  exMemDataQ, memWbWeQ, memWbDestQ, memWbDataQ, gprQ[rt]);

    always_comb begin
        idExWeD   = 1'b0;
        idExDestD = rd;
        idExOpD   = ALU_AND;
        idExAD    = rsVal;
        idExBD    = rtVal;
        idExShD   = sa;
        case (opcode)
            6'h00: begin
                idExWeD = 1'b1;
                case (funct)
                    6'h24:   idExOpD = ALU_AND;
                    6'h25:   idExOpD = ALU_OR;
                    6'h26:   idExOpD = ALU_XOR;
                    6'h27:   idExOpD = ALU_NOR;
                    6'h21:   idExOpD = ALU_ADD;
                    6'h23:   idExOpD = ALU_SUB;
                    6'h2A:   idExOpD = ALU_SLT;
                    6'h00:   idExOpD = ALU_SLL;
                    6'h02:   idExOpD = ALU_SRL;
                    default: idExWeD = 1'b0;
                endcase
            end
            6'h0C: begin
                idExWeD = 1'b1; idExDestD = rt; idExOpD = ALU_AND; idExBD = {16'h0, imm};
            end
            6'h0D: begin
                idExWeD = 1'b1; idExDestD = rt; idExOpD = ALU_OR; idExBD = {16'h0, imm};
            end
            6'h0E: begin
                idExWeD = 1'b1; idExDestD = rt; idExOpD = ALU_XOR; idExBD = {16'h0, imm};
            end
            6'h0F: begin
                idExWeD = 1'b1; idExDestD = rt; idExOpD = ALU_PASSB; idExBD = {imm, 16'h0};
            end
            default: idExWeD = 1'b0;
        endcase
        // $0 is hardwired; dropping the write here also keeps it out of forwarding.
        if (idExDestD == 5'd0) idExWeD = 1'b0;
    end

    always_comb begin
        exResult = '0;
        case (idExOpQ)
            ALU_AND:   exResult = idExAQ & idExBQ;
            ALU_OR:    exResult = idExAQ | idExBQ;
            ALU_XOR:   exResult = idExAQ ^ idExBQ;
            ALU_NOR:   exResult = ~(idExAQ | idExBQ);
            ALU_ADD:   exResult = idExAQ + idExBQ;
            ALU_SUB:   exResult = idExAQ - idExBQ;
            ALU_SLT:   exResult = {31'd0, $signed(idExAQ) < $signed(idExBQ)};
            ALU_SLL:   exResult = idExBQ << idExShQ;
            ALU_SRL:   exResult = idExBQ >> idExShQ;
            ALU_PASSB: exResult = idExBQ;
            default:   exResult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcQ        <= '0;
            ifIdInstQ  <= '0;
            idExWeQ    <= 1'b0;
            idExDestQ  <= '0;
            idExOpQ    <= ALU_AND;
            idExAQ     <= '0;
            idExBQ     <= '0;
            idExShQ    <= '0;
            exMemWeQ   <= 1'b0;
            exMemDestQ <= '0;
            exMemDataQ <= '0;
            memWbWeQ   <= 1'b0;
            memWbDestQ <= '0;
            memWbDataQ <= '0;
        end else begin
            pcQ        <= pcD;
            ifIdInstQ  <= fetchInst;
            idExWeQ    <= idExWeD;
            idExDestQ  <= idExDestD;
            idExOpQ    <= idExOpD;
            idExAQ     <= idExAD;
            idExBQ     <= idExBD;
            idExShQ    <= idExShD;
            exMemWeQ   <= idExWeQ;
            exMemDestQ <= idExDestQ;
            exMemDataQ <= exResult;
            memWbWeQ   <= exMemWeQ;
            memWbDestQ <= exMemDestQ;
            memWbDataQ <= exMemDataQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) gprQ[i] <= '0;
        end else if (memWbWeQ) begin
            gprQ[memWbDestQ] <= memWbDataQ;
        end
    end

    assign dbg_pc      = pcQ;
    assign dbg_wb_we   = memWbWeQ;
    assign dbg_wb_addr = memWbDestQ;
    assign dbg_wb_data = memWbDataQ;
endmodule

// File: tb/tb_expye_pipe_cpu.sv
// Scoreboard bench for expye_pipe_cpu: an ISA-level model executes each fetched instruction in
// program order and queues the write-back it expects; a separate monitor compares every cycle.
module tb_expye_pipe_cpu;
    localparam int DEPTH = 128;

    function automatic logic [31:0] makeInst(input logic [31:0] r);
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        logic [31:0] inst;
        rs  = {2'b00, r[2:0]};
        rt  = {2'b00, r[5:3]};
        rd  = {2'b00, r[8:6]};
        sa  = r[13:9];
        imm = r[27:12];
        case (r[31:28])
            4'd0:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd1:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd2:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h26};
            4'd3:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h27};
            4'd4:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            4'd5:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            4'd6:    inst = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd7:    inst = {6'h00, 5'd0, rt, rd, sa, 6'h00};
            4'd8:    inst = {6'h00, 5'd0, rt, rd, sa, 6'h02};
            4'd9:    inst = {6'h0D, rs, rt, imm};
            4'd10:   inst = {6'h0C, rs, rt, imm};
            4'd11:   inst = {6'h0E, rs, rt, imm};
            4'd12:   inst = {6'h0F, 5'd0, rt, imm};
            4'd13:   inst = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd14:   inst = {6'h08, rs, rt, imm};
            default: inst = {6'h0D, rs, 5'd0, imm};
        endcase
        return inst;
    endfunction

    // Fixed opening sequence followed by pseudo-random ALU traffic on $0..$7.
    function automatic logic [DEPTH*32-1:0] buildRom();
        logic [DEPTH*32-1:0] img;
        logic [31:0]         lcg;
        img = '0;
        img[0*32 +: 32] = 32'h34011100;
        img[1*32 +: 32] = 32'h34220020;
        img[2*32 +: 32] = 32'h00221821;
        img[3*32 +: 32] = 32'h00412023;
        img[4*32 +: 32] = 32'h3C05ABCD;
        img[5*32 +: 32] = 32'h3400FFFF;
        img[6*32 +: 32] = 32'hFC000000;
        lcg = 32'h1234_5678;
        for (int i = 7; i < 100; i++) begin
            lcg = lcg * 32'd1664525 + 32'd1013904223;
            img[i*32 +: 32] = makeInst({lcg[15:0], lcg[31:16]} ^ (lcg >> 7));
        end
        return img;
    endfunction

    localparam logic [DEPTH*32-1:0] PROG = buildRom();
    localparam logic [31:0] HEAD_DATA [5] = '{32'h00001100, 32'h00001120, 32'h00002220,
                                              32'h00000020, 32'hABCD0000};

    typedef struct {
        int          stamp;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbg_pc;
    logic        dbg_wb_we;
    logic [4:0]  dbg_wb_addr;
    logic [31:0] dbg_wb_data;

    exp_t        scoreQ[$];
    logic [31:0] mRegs [32];
    logic [31:0] mPc;
    int          fetchNo;
    int          edgeCnt = 0;
    int          checks  = 0;
    int          fails   = 0;

    expye_pipe_cpu #(.ROM_DEPTH(DEPTH), .ROM_INIT(PROG)) dut (
        .clk         (clk),
        .rst         (rst),
        .dbg_pc      (dbg_pc),
        .dbg_wb_we   (dbg_wb_we),
        .dbg_wb_addr (dbg_wb_addr),
        .dbg_wb_data (dbg_wb_data)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mPc     = '0;
        fetchNo = 0;
        scoreQ.delete();
    endtask

    task automatic modelStep();
        logic [31:0] inst, a, b, res;
        logic [4:0]  dst;
        logic        we;
        int          idx;
        exp_t        e;
        idx  = int'(mPc / 4) % DEPTH;
        inst = PROG[idx*32 +: 32];
        mPc  = (mPc + 32'd4) % (DEPTH * 4);
        a    = mRegs[inst[25:21]];
        b    = mRegs[inst[20:16]];
        we   = 1'b1;
        res  = '0;
        dst  = inst[15:11];
        case (inst[31:26])
            6'h00: case (inst[5:0])
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h26:   res = a ^ b;
                6'h27:   res = ~(a | b);
                6'h21:   res = a + b;
                6'h23:   res = a - b;
                6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00:   res = b << inst[10:6];
                6'h02:   res = b >> inst[10:6];
                default: we = 1'b0;
            endcase
            6'h0C: begin res = a & {16'h0, inst[15:0]}; dst = inst[20:16]; end
            6'h0D: begin res = a | {16'h0, inst[15:0]}; dst = inst[20:16]; end
            6'h0E: begin res = a ^ {16'h0, inst[15:0]}; dst = inst[20:16]; end
            6'h0F: begin res = {inst[15:0], 16'h0};     dst = inst[20:16]; end
            default: we = 1'b0;
        endcase
        if (dst == 5'd0) we = 1'b0;
        if (we) begin
            mRegs[dst] = res;
            e.stamp = edgeCnt + 3;
            if (fetchNo < 5) begin
                e.addr = 5'(fetchNo + 1);
                e.data = HEAD_DATA[fetchNo];
            end else begin
                e.addr = dst;
                e.data = res;
            end
            scoreQ.push_back(e);
        end
        fetchNo++;
    endtask

    // Inputs change 3 time units after a rising edge; the model advances on edges taken with rst high.
    task automatic applyStimulus(input logic rstVal, input int cycles);
        rst = rstVal;
        if (!rstVal) modelReset();
        repeat (cycles) begin
            @(posedge clk);
            edgeCnt++;
            if (rst) modelStep();
            #3;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at edge %0d: got 0x%08h, expected 0x%08h",
                     name, edgeCnt, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checkOutput("rstPc", dbg_pc, 32'd0);
            checkOutput("rstWbCtl", {26'd0, dbg_wb_we, dbg_wb_addr}, 32'd0);
            checkOutput("rstWbData", dbg_wb_data, 32'd0);
        end else begin
            checkOutput("pc", dbg_pc, mPc);
            if (dbg_wb_we) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("wbUnexpected", 32'(dbg_wb_we), 32'd0);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("wbTiming", 32'(edgeCnt), 32'(e.stamp));
                    checkOutput("wbAddr", 32'(dbg_wb_addr), 32'(e.addr));
                    checkOutput("wbData", dbg_wb_data, e.data);
                end
            end else if (scoreQ.size() > 0 && scoreQ[0].stamp <= edgeCnt) begin
                e = scoreQ.pop_front();
                checkOutput("wbMissing", 32'(dbg_wb_we), 32'd1);
            end
        end
    end

    initial begin
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 20);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b0, $urandom_range(1, 3));
            applyStimulus(1'b1, $urandom_range(10, 70));
        end
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 150);
        applyStimulus(1'b0, 2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
